dense_layer: RTL and testbench

Fully-connected layer that consumes the 2×2-pooled feature map directly downstream of the max-pool stage. It reads the POOL buffer (CHW-flattened) and a weight ROM and a bias ROM, all synchronous BRAMs with 1-cycle read latency. It computes OUT_DIM fixed-point dot products and writes them into a LOGIT buffer for the argmax/classifier stage. It is start/done sequenced like the other layer engines, with one output neuron processed at a time and one MAC per cycle.

---
 rtl/cnn_pkg.sv | 36 +++
 rtl/dense_layer_if.sv | 43 ++++
 rtl/dense_mac.sv | 37 +++
 rtl/dense_layer.sv | 210 +++++++++++++++++++++
 tb/tb_dense_layer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: fixed-point types, FSM states and requant helper
// shared by the CNN layer engines.
package cnn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 7;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_LAST,
    S_WRITE,
    S_FINISH
  } dense_st_t;

  // Floor shift, then clamp into a dw-bit signed range.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 dw
  );
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (sh > hi) sh = hi;
    else if (sh < lo) sh = lo;
    return sh;
  endfunction

endpackage

// File: rtl/dense_layer_if.sv
// dense_layer_if: start/done control plus pool, weight,
// bias and logit buffer ports of the dense layer engine.
interface dense_layer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_AW      = 11,
  parameter int W_AW       = 14,
  parameter int OUT_AW     = 4
);

  logic                         start;
  logic [IN_AW-1:0]             in_addr;
  logic                         in_en;
  logic signed [DATA_WIDTH-1:0] in_q;
  logic [W_AW-1:0]              w_addr;
  logic                         w_en;
  logic signed [DATA_WIDTH-1:0] w_q;
  logic [OUT_AW-1:0]            b_addr;
  logic                         b_en;
  logic signed [DATA_WIDTH-1:0] b_q;
  logic [OUT_AW-1:0]            out_addr;
  logic                         out_en;
  logic                         out_we;
  logic signed [DATA_WIDTH-1:0] out_d;
  logic                         busy;
  logic                         done;

  modport master (
    input  start, in_q, w_q, b_q,
    output in_addr, in_en, w_addr, w_en,
    output b_addr, b_en,
    output out_addr, out_en, out_we, out_d,
    output busy, done
  );

  modport slave (
    output start, in_q, w_q, b_q,
    input  in_addr, in_en, w_addr, w_en,
    input  b_addr, b_en,
    input  out_addr, out_en, out_we, out_d,
    input  busy, done
  );

endinterface

// File: rtl/dense_mac.sv
// dense_mac: registered signed MAC with clear,
// bias-load (pre-scaled to the Q format) and accumulate.
module dense_mac
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = cnn_pkg::FRAC_BITS,
  parameter int ACC_W      = 2 * DATA_WIDTH + 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         load,
  input  logic                         acc_en,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_W-1:0]      acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(bias) <<< FRAC_BITS;
    end else if (acc_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/dense_layer.sv
// dense_layer: one-neuron-at-a-time FC engine, one MAC/cycle.
// DENSE_RELU_EN clamps negative logits to zero.
module dense_layer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = cnn_pkg::FRAC_BITS,
  parameter int IN_DIM     = 1568,
  parameter int OUT_DIM    = 10,
  parameter int IN_AW      = $clog2(IN_DIM),
  parameter int W_AW       = $clog2(IN_DIM * OUT_DIM),
  parameter int OUT_AW     =
    (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input logic          clk,
  input logic          reset,
  dense_layer_if.master bus
);

  localparam int ACC_W =
    2 * DATA_WIDTH + $clog2(IN_DIM) + 1;

  localparam logic [IN_AW-1:0] I_LAST =
    IN_AW'(IN_DIM - 1);
  localparam logic [OUT_AW-1:0] O_LAST =
    OUT_AW'(OUT_DIM - 1);
  localparam logic [W_AW-1:0] W_STEP = W_AW'(IN_DIM);

  dense_st_t st_q, st_nx;

  logic [OUT_AW-1:0] o_q, o_nx;
  logic [IN_AW-1:0]  i_q, i_nx;
  logic [W_AW-1:0]   base_q, base_nx;

  logic [IN_AW-1:0]  in_addr_q, in_addr_nx;
  logic [W_AW-1:0]   w_addr_q, w_addr_nx;
  logic [OUT_AW-1:0] b_addr_q, b_addr_nx;
  logic [OUT_AW-1:0] out_addr_q, out_addr_nx;
  logic signed [DATA_WIDTH-1:0] out_d_q, out_d_nx;

  logic in_en_q, in_en_nx;
  logic w_en_q, w_en_nx;
  logic b_en_q, b_en_nx;
  logic out_en_q, out_en_nx;
  logic out_we_q, out_we_nx;
  logic busy_q, busy_nx;
  logic done_q, done_nx;

  // Read data lands one cycle after the registered enable.
  logic b_v_q;
  logic m_v_q;

  logic signed [ACC_W-1:0]      acc;
  logic signed [DATA_WIDTH-1:0] rq;

  dense_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (st_q == S_IDLE),
    .load   (b_v_q),
    .acc_en (m_v_q),
    .bias   (bus.b_q),
    .a      (bus.in_q),
    .b      (bus.w_q),
    .acc    (acc)
  );

  always_comb begin
    rq = DATA_WIDTH'(
      sat_shift(64'(acc), FRAC_BITS, DATA_WIDTH));
`ifdef DENSE_RELU_EN
    if (rq < 0) rq = '0;
`endif
  end

  always_comb begin
    st_nx       = st_q;
    o_nx        = o_q;
    i_nx        = i_q;
    base_nx     = base_q;
    in_addr_nx  = in_addr_q;
    w_addr_nx   = w_addr_q;
    b_addr_nx   = b_addr_q;
    out_addr_nx = out_addr_q;
    out_d_nx    = out_d_q;
    busy_nx     = busy_q;
    in_en_nx    = 1'b0;
    w_en_nx     = 1'b0;
    b_en_nx     = 1'b0;
    out_en_nx   = 1'b0;
    out_we_nx   = 1'b0;
    done_nx     = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (bus.start) begin
          o_nx      = '0;
          i_nx      = '0;
          base_nx   = '0;
          b_addr_nx = '0;
          b_en_nx   = 1'b1;
          busy_nx   = 1'b1;
          st_nx     = S_BIAS;
        end
      end
      S_BIAS: begin
        i_nx       = '0;
        in_addr_nx = '0;
        w_addr_nx  = base_q;
        in_en_nx   = 1'b1;
        w_en_nx    = 1'b1;
        st_nx      = S_MAC;
      end
      S_MAC: begin
        if (i_q == I_LAST) begin
          st_nx = S_LAST;
        end else begin
          i_nx       = i_q + 1'b1;
          in_addr_nx = i_q + 1'b1;
          w_addr_nx  = w_addr_q + 1'b1;
          in_en_nx   = 1'b1;
          w_en_nx    = 1'b1;
        end
      end
      S_LAST: begin
        st_nx = S_WRITE;
      end
      S_WRITE: begin
        out_addr_nx = o_q;
        out_en_nx   = 1'b1;
        out_we_nx   = 1'b1;
        out_d_nx    = rq;
        if (o_q == O_LAST) begin
          st_nx = S_FINISH;
        end else begin
          o_nx      = o_q + 1'b1;
          base_nx   = base_q + W_STEP;
          b_addr_nx = o_q + 1'b1;
          b_en_nx   = 1'b1;
          st_nx     = S_BIAS;
        end
      end
      S_FINISH: begin
        done_nx = 1'b1;
        busy_nx = 1'b0;
        st_nx   = S_IDLE;
      end
      default: st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= S_IDLE;
      o_q        <= '0;
      i_q        <= '0;
      base_q     <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
      out_addr_q <= '0;
      out_d_q    <= '0;
      in_en_q    <= 1'b0;
      w_en_q     <= 1'b0;
      b_en_q     <= 1'b0;
      out_en_q   <= 1'b0;
      out_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      b_v_q      <= 1'b0;
      m_v_q      <= 1'b0;
    end else begin
      st_q       <= st_nx;
      o_q        <= o_nx;
      i_q        <= i_nx;
      base_q     <= base_nx;
      in_addr_q  <= in_addr_nx;
      w_addr_q   <= w_addr_nx;
      b_addr_q   <= b_addr_nx;
      out_addr_q <= out_addr_nx;
      out_d_q    <= out_d_nx;
      in_en_q    <= in_en_nx;
      w_en_q     <= w_en_nx;
      b_en_q     <= b_en_nx;
      out_en_q   <= out_en_nx;
      out_we_q   <= out_we_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
      b_v_q      <= b_en_q;
      m_v_q      <= in_en_q;
    end
  end

  assign bus.in_addr  = in_addr_q;
  assign bus.in_en    = in_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_en     = w_en_q;
  assign bus.b_addr   = b_addr_q;
  assign bus.b_en     = b_en_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_en   = out_en_q;
  assign bus.out_we   = out_we_q;
  assign bus.out_d    = out_d_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_dense_layer.sv
// tb_dense_layer: directed and random checks of dense_layer
// on a 4x2 instance and a full-size 1568x10 instance.
module tb_dense_layer;

  localparam int DW = 16;
  localparam int FB = 7;

  localparam int S_IN  = 4;
  localparam int S_OUT = 2;
  localparam int S_IAW = $clog2(S_IN);
  localparam int S_WAW = $clog2(S_IN * S_OUT);
  localparam int S_OAW = (S_OUT > 1) ? $clog2(S_OUT) : 1;
  localparam int S_LAT = 1 + S_OUT * (S_IN + 3) + 1;

  localparam int L_IN  = 1568;
  localparam int L_OUT = 10;
  localparam int L_IAW = $clog2(L_IN);
  localparam int L_WAW = $clog2(L_IN * L_OUT);
  localparam int L_OAW = (L_OUT > 1) ? $clog2(L_OUT) : 1;
  localparam int L_LAT = 1 + L_OUT * (L_IN + 3) + 1;

`ifdef DENSE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  dense_layer_if #(
    .DATA_WIDTH(DW), .IN_AW(S_IAW),
    .W_AW(S_WAW), .OUT_AW(S_OAW)
  ) sb ();

  dense_layer_if #(
    .DATA_WIDTH(DW), .IN_AW(L_IAW),
    .W_AW(L_WAW), .OUT_AW(L_OAW)
  ) lb ();

  dense_layer #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB),
    .IN_DIM(S_IN), .OUT_DIM(S_OUT)
  ) u_s (.clk(clk), .reset(rst_n), .bus(sb.master));

  dense_layer #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB),
    .IN_DIM(L_IN), .OUT_DIM(L_OUT)
  ) u_l (.clk(clk), .reset(rst_n), .bus(lb.master));

  logic signed [DW-1:0] s_in [S_IN];
  logic signed [DW-1:0] s_w  [S_IN*S_OUT];
  logic signed [DW-1:0] s_b  [S_OUT];
  logic signed [DW-1:0] l_in [L_IN];
  logic signed [DW-1:0] l_w  [L_IN*L_OUT];
  logic signed [DW-1:0] l_b  [L_OUT];

  longint s_exp [S_OUT];
  longint l_exp [L_OUT];

  // synchronous 1-cycle-latency memory models
  always @(posedge clk) begin
    if (sb.in_en) sb.in_q <= s_in[sb.in_addr];
    if (sb.w_en)  sb.w_q  <= s_w[sb.w_addr];
    if (sb.b_en)  sb.b_q  <= s_b[sb.b_addr];
    if (lb.in_en) lb.in_q <= l_in[lb.in_addr];
    if (lb.w_en)  lb.w_q  <= l_w[lb.w_addr];
    if (lb.b_en)  lb.b_q  <= l_b[lb.b_addr];
  end

  int s_rd = 0;
  int l_rd = 0;
  int l_viol = 0;
  int l_wmax = 0;
  logic [S_OAW-1:0]     s_wa [$];
  logic signed [DW-1:0] s_wd [$];
  logic [L_OAW-1:0]     l_wa [$];
  logic signed [DW-1:0] l_wd [$];

  always @(posedge clk) begin
    if (sb.in_en) s_rd <= s_rd + 1;
    if (sb.out_en && sb.out_we) begin
      s_wa.push_back(sb.out_addr);
      s_wd.push_back(sb.out_d);
    end
    if (lb.in_en) l_rd <= l_rd + 1;
    if ((lb.in_en && int'(lb.in_addr) >= L_IN) ||
        (lb.w_en && int'(lb.w_addr) >= L_IN * L_OUT))
      l_viol <= l_viol + 1;
    if (lb.w_en && int'(lb.w_addr) > l_wmax)
      l_wmax <= int'(lb.w_addr);
    if (lb.out_en && lb.out_we) begin
      l_wa.push_back(lb.out_addr);
      l_wd.push_back(lb.out_d);
    end
  end

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic longint requant(input longint acc);
    longint v;
    v = acc >>> FB;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    if (RELU && v < 0) v = 0;
    return v;
  endfunction

  task automatic s_model();
    longint acc;
    for (int o = 0; o < S_OUT; o++) begin
      acc = longint'(s_b[o]) * (longint'(1) << FB);
      for (int i = 0; i < S_IN; i++)
        acc += longint'(s_in[i]) * longint'(s_w[o*S_IN+i]);
      s_exp[o] = requant(acc);
    end
  endtask

  task automatic l_model();
    longint acc;
    for (int o = 0; o < L_OUT; o++) begin
      acc = longint'(l_b[o]) * (longint'(1) << FB);
      for (int i = 0; i < L_IN; i++)
        acc += longint'(l_in[i]) * longint'(l_w[o*L_IN+i]);
      l_exp[o] = requant(acc);
    end
  endtask

  task automatic s_fill(input int iv, input int w0,
                        input int w1, input int b0,
                        input int b1);
    for (int i = 0; i < S_IN; i++) begin
      s_in[i]      = DW'(iv);
      s_w[i]       = DW'(w0);
      s_w[S_IN+i]  = DW'(w1);
    end
    s_b[0] = DW'(b0);
    s_b[1] = DW'(b1);
  endtask

  // One pass; extra=1 adds start pulses mid-pass and in FINISH.
  task automatic s_run(input string tag, input int extra,
                       output int base);
    int n;
    int rd0;
    s_model();
    base = s_wa.size();
    rd0  = s_rd;
    @(posedge clk); #1;
    sb.start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) sb.start = 1'b0;
      if (extra != 0 && (n == 5 || n == S_LAT - 1))
        sb.start = 1'b1;
      if (extra != 0 && (n == 6 || n == S_LAT))
        sb.start = 1'b0;
    end while (!sb.done && n < S_LAT + 50);
    sb.start = 1'b0;
    chk({tag, "_lat"}, n, S_LAT);
    chk({tag, "_nwr"}, s_wa.size() - base, S_OUT);
    for (int k = 0; k < S_OUT; k++) begin
      chk({tag, "_addr"}, s_wa[base+k], k);
      chk({tag, "_data"}, s_wd[base+k], s_exp[k]);
    end
    chk({tag, "_reads"}, s_rd - rd0, S_IN * S_OUT);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_idle"}, {sb.busy, sb.done}, 0);
    chk({tag, "_norestart"}, s_wa.size() - base, S_OUT);
  endtask

  initial begin
    int b;
    int n;
    int wn;
    sb.start = 1'b0;
    lb.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_done", {sb.busy, sb.done}, 0);
    chk("rst_en", {sb.in_en, sb.w_en, sb.b_en,
                   sb.out_en, sb.out_we}, 0);
    chk("rst_addr", {sb.in_addr, sb.w_addr,
                     sb.b_addr, sb.out_addr}, 0);
    chk("rst_outd", sb.out_d, 0);
    chk("rst_big", {lb.busy, lb.done, lb.w_addr}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    s_fill(128, 64, 64, 0, 0);
    s_run("t1", 0, b);
    chk("t1_l0", s_wd[b], 256);
    chk("t1_l1", s_wd[b+1], 256);

    s_fill(128, 64, -64, 0, -128);
    s_run("t2", 0, b);
    chk("t2_l1", s_wd[b+1], RELU ? 0 : -384);

    s_fill(32767, 32767, 32767, 0, 0);
    s_run("t3", 0, b);
    chk("t3_pos_sat", s_wd[b], 32767);

    s_fill(32767, -32768, -32768, 0, 0);
    s_run("t4", 0, b);
    chk("t4_neg_sat", s_wd[b+1], RELU ? 0 : -32768);

    s_fill(0, 0, 0, 0, 0);
    s_in[0] = 16'sd1;
    s_w[0]  = -16'sd1;
    s_run("t5", 0, b);
    chk("t5_floor", s_wd[b], RELU ? 0 : -1);

    // reset pulse while neuron 0 is in MAC
    s_fill(128, 64, 64, 0, 0);
    wn = s_wa.size();
    @(posedge clk); #1;
    sb.start = 1'b1;
    @(posedge clk); #1;
    sb.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {sb.busy, sb.done, sb.in_en,
                        sb.w_en, sb.b_en, sb.out_en,
                        sb.out_we}, 0);
    chk("mid_rst_addr", {sb.in_addr, sb.w_addr,
                         sb.b_addr, sb.out_addr}, 0);
    chk("mid_rst_outd", sb.out_d, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_nowr", s_wa.size() - wn, 0);

    s_run("t6", 1, b);
    chk("t6_l0", s_wd[b], 256);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < S_IN * S_OUT; i++) begin
        if (it % 2 == 0) begin
          s_w[i] = DW'($urandom_range(0, 65535));
          if (i < S_IN) s_in[i] = DW'($urandom_range(0, 65535));
        end else begin
          s_w[i] = DW'(int'($urandom_range(0, 511)) - 256);
          if (i < S_IN)
            s_in[i] = DW'(int'($urandom_range(0, 511)) - 256);
        end
      end
      for (int o = 0; o < S_OUT; o++)
        s_b[o] = DW'(int'($urandom_range(0, 4095)) - 2048);
      s_run("rnd", 0, b);
    end

    for (int i = 0; i < L_IN; i++)
      l_in[i] = DW'(int'($urandom_range(0, 127)) - 64);
    for (int i = 0; i < L_IN * L_OUT; i++)
      l_w[i] = DW'(int'($urandom_range(0, 127)) - 64);
    for (int o = 0; o < L_OUT; o++)
      l_b[o] = DW'(int'($urandom_range(0, 4095)) - 2048);
    l_model();
    b = l_wa.size();
    wn = l_rd;
    @(posedge clk); #1;
    lb.start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) lb.start = 1'b0;
    end while (!lb.done && n < L_LAT + 100);
    chk("big_lat", n, L_LAT);
    chk("big_nwr", l_wa.size() - b, L_OUT);
    for (int k = 0; k < L_OUT; k++) begin
      chk("big_addr", l_wa[b+k], k);
      chk("big_data", l_wd[b+k], l_exp[k]);
    end
    chk("big_wmax", l_wmax, L_IN * L_OUT - 1);
    chk("big_reads", l_rd - wn, L_IN * L_OUT);
    chk("big_bounds", l_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
